// File: rtl/reg_file.sv
// Decode-stage register bank: 2^ADDR_WIDTH x DATA_WIDTH registers, two
// registered operand read ports (busA/busB) feeding the ALU, one writeback
// write port with same-edge bypass, stall hold, flush bubble and an
// asynchronous debug read port. Register 0 is hardwired to zero.

// One registered operand read port. It is instantiated once per operand.
module reg_file_rdport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 1 << ADDR_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 stall,
  input  logic                                 flush,
  input  logic [ADDR_WIDTH-1:0]                rd_addr,
  input  logic                                 wr_en,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs,
  output logic [DATA_WIDTH-1:0]                bus
);

  logic [DATA_WIDTH-1:0] val;
  logic [DATA_WIDTH-1:0] bus_d, bus_q;

  // Operand value: zero register first, then writeback bypass, then storage.
  always_comb begin
    val = regs[rd_addr];
    if (rd_addr == '0)
      val = '0;
    else if (wr_en && (wr_addr == rd_addr))
      val = wr_data;
  end

  // Next bus value: flush bubble beats stall hold, which beats a fresh read.
  always_comb begin
    bus_d = bus_q;
    if (flush)
      bus_d = '0;
    else if (!stall)
      bus_d = val;
  end

  // Operand output register, cleared immediately on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus_q <= '0;
    else          bus_q <= bus_d;
  end

  assign bus = bus_q;

endmodule

module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] rsAddr,
  input  logic [ADDR_WIDTH-1:0] rtAddr,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] dbgAddr,
  output logic [DATA_WIDTH-1:0] busA,
  output logic [DATA_WIDTH-1:0] busB,
  output logic [DATA_WIDTH-1:0] dbgData
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  localparam int NUM_RD   = 2;

  // Storage for registers 1..NUM_REGS-1; register 0 has no flops.
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];

  // Flat view of the bank with entry 0 tied to zero, shared by all readers.
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_flat;

  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_bus;

  logic wr_en;

  // Address 0 writes are dropped here so neither storage nor bypass sees them.
  assign wr_en = regWrite && (writeAddr != '0);

  // Register storage: async clear, write happens regardless of stall/flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[writeAddr] <= writeData;
    end
  end

  // Flatten storage into a packed array with a constant-zero register 0.
  always_comb begin
    regs_flat    = '0;
    for (int i = 1; i < NUM_REGS; i++) regs_flat[i] = regs_q[i];
  end

  assign rd_addr[0] = rsAddr;
  assign rd_addr[1] = rtAddr;

  genvar g;
  generate
    for (g = 0; g < NUM_RD; g++) begin : g_rd
      reg_file_rdport #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
      ) u_rd (
        .clk     (clk),
        .reset_n (reset_n),
        .stall   (stall),
        .flush   (flush),
        .rd_addr (rd_addr[g]),
        .wr_en   (wr_en),
        .wr_addr (writeAddr),
        .wr_data (writeData),
        .regs    (regs_flat),
        .bus     (rd_bus[g])
      );
    end
  endgenerate

  assign busA = rd_bus[0];
  assign busB = rd_bus[1];

  // Debug read sees storage only (no bypass), so a write shows up next cycle.
  assign dbgData = regs_flat[dbgAddr];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random traffic,
// compared against an array-based reference model of the register bank.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          stall, flush, regWrite;
  logic [AW-1:0] rsAddr, rtAddr, writeAddr, dbgAddr;
  logic [DW-1:0] writeData;
  logic [DW-1:0] busA, busB, dbgData;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] m_a, m_b;

  always #5 clk = ~clk;

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .rsAddr(rsAddr), .rtAddr(rtAddr), .regWrite(regWrite),
    .writeAddr(writeAddr), .writeData(writeData), .dbgAddr(dbgAddr),
    .busA(busA), .busB(busB), .dbgData(dbgData)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mval(input logic [AW-1:0] a, input logic we,
                                         input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (a == 0)                return '0;
    if (we && wa == a)         return wd;
    return m_regs[a];
  endfunction

  function automatic logic [DW-1:0] mdbg(input logic [AW-1:0] a);
    return (a == 0) ? '0 : m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_a = '0;
    m_b = '0;
  endtask

  // One clock: drive at negedge, update the model, check shortly after posedge.
  task automatic step(input string tag, input logic st, input logic fl,
                      input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                      input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [AW-1:0] da);
    logic [DW-1:0] na, nb;
    @(negedge clk);
    stall = st; flush = fl; rsAddr = rs; rtAddr = rt;
    regWrite = we; writeAddr = wa; writeData = wd; dbgAddr = da;
    na = fl ? '0 : (st ? m_a : mval(rs, we, wa, wd));
    nb = fl ? '0 : (st ? m_b : mval(rt, we, wa, wd));
    if (we && wa != 0) m_regs[wa] = wd;
    m_a = na;
    m_b = nb;
    @(posedge clk);
    #1;
    chk({tag, ".busA"}, busA, m_a);
    chk({tag, ".busB"}, busB, m_b);
    chk({tag, ".dbg"},  dbgData, mdbg(da));
  endtask

  initial begin
    reset_n = 1'b0; stall = 0; flush = 0; regWrite = 0;
    rsAddr = 0; rtAddr = 0; writeAddr = 0; writeData = 0; dbgAddr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("por.busA", busA, '0);
    chk("por.busB", busB, '0);

    // Preload regs 1..31 with nonzero values, leave buses nonzero.
    for (int i = 1; i < NR; i++)
      step("preload", 0, 0, 5'd1, 5'd2, 1, i[AW-1:0], 32'hA500_0000 + DW'(i), 5'd1);
    step("preload.rd", 0, 0, 5'd30, 5'd31, 0, 5'd0, '0, 5'd5);
    chk("preload.nz", {31'b0, busA != 0}, 32'd1);

    // Reset pulse between edges with a write pending: immediate clear.
    @(negedge clk);
    regWrite = 1; writeAddr = 5'd5; writeData = 32'h1234_5678; dbgAddr = 5'd5;
    #1 reset_n = 1'b0;
    #1;
    chk("rst.busA", busA, '0);
    chk("rst.busB", busB, '0);
    chk("rst.dbg5", dbgData, '0);
    #2 reset_n = 1'b1;
    model_reset();
    regWrite = 0;
    @(posedge clk); #1;
    chk("rst.keep5", dbgData, '0);

    // Write/read.
    step("wr3", 0, 0, 5'd0, 5'd0, 1, 5'd3, 32'd2, 5'd3);
    step("wr4", 0, 0, 5'd0, 5'd0, 1, 5'd4, 32'd4, 5'd4);
    step("rd34", 0, 0, 5'd3, 5'd4, 0, 5'd0, '0, 5'd0);
    chk("rd34.A", busA, 32'd2);
    chk("rd34.B", busB, 32'd4);

    // Same-edge bypass on both ports.
    step("byp", 0, 0, 5'd7, 5'd7, 1, 5'd7, 32'hDEADBEEF, 5'd7);
    chk("byp.A", busA, 32'hDEADBEEF);
    chk("byp.B", busB, 32'hDEADBEEF);
    step("byp.dbg", 0, 0, 5'd3, 5'd4, 0, 5'd0, '0, 5'd7);
    chk("byp.dbg7", dbgData, 32'hDEADBEEF);

    // Register 0 ignores writes, also through the bypass.
    step("r0", 0, 0, 5'd0, 5'd3, 1, 5'd0, 32'hFFFFFFFF, 5'd0);
    chk("r0.A", busA, '0);
    chk("r0.dbg", dbgData, '0);

    // Stall hold with a write to the stalled register, then release, then flush+stall.
    step("st.pre", 0, 0, 5'd3, 5'd4, 0, 5'd0, '0, 5'd3);
    chk("st.pre.A", busA, 32'd2);
    step("st.wr", 1, 0, 5'd3, 5'd4, 1, 5'd3, 32'd9, 5'd3);
    chk("st.hold", busA, 32'd2);
    step("st.rel", 0, 0, 5'd3, 5'd4, 0, 5'd0, '0, 5'd3);
    chk("st.rel.A", busA, 32'd9);
    step("fl.st", 1, 1, 5'd3, 5'd4, 0, 5'd0, '0, 5'd3);
    chk("fl.A", busA, '0);
    chk("fl.B", busB, '0);

    // Sweep: reg i = 3i, then read pairs (i, 31-i).
    for (int i = 1; i < NR; i++)
      step("sw.wr", 0, 0, 5'd0, 5'd0, 1, i[AW-1:0], DW'(3 * i), i[AW-1:0]);
    for (int i = 0; i < NR; i++) begin
      step("sw.rd", 0, 0, i[AW-1:0], AW'(31 - i), 0, 5'd0, '0, i[AW-1:0]);
      chk("sw.A", busA, DW'(3 * i));
      chk("sw.B", busB, DW'(3 * (31 - i)));
    end

    // Random traffic; addresses drawn from a small set to raise bypass hits.
    for (int n = 0; n < 400; n++) begin
      logic st, fl, we;
      logic [AW-1:0] rs, rt, wa, da;
      st = ($urandom_range(0, 5) == 0);
      fl = ($urandom_range(0, 9) == 0);
      we = $urandom_range(0, 1);
      rs = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      rt = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      wa = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      da = AW'($urandom);
      step("rnd", st, fl, rs, rt, we, wa, DW'($urandom), da);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Register bank for the decode stage, directly upstream of the ALU.
- Holds 2^ADDR_WIDTH general registers and registers two operand reads per clock onto busA and busB, which feed the ALU operand inputs.
- One write port is driven from writeback.
- Same-edge write-to-read bypass, stall hold, flush bubble, and an asynchronous debug read port.

Parameters:
- DATA_WIDTH, 32, width of each register and of busA, busB, writeData and dbgData.
- ADDR_WIDTH, 5, register address width; register count is 2^ADDR_WIDTH (32 at default).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- stall  input  1  1 = hold busA/busB at their current values.
- flush  input  1  1 = load zeros into busA/busB (bubble); has priority over stall.
- rsAddr  input  ADDR_WIDTH  read address for operand A.
- rtAddr  input  ADDR_WIDTH  read address for operand B.
- regWrite  input  1  write enable.
- writeAddr  input  ADDR_WIDTH  write address.
- writeData  input  DATA_WIDTH  write data.
- dbgAddr  input  ADDR_WIDTH  debug read address.
- busA  output  DATA_WIDTH  registered operand A, to the ALU busA input.
- busB  output  DATA_WIDTH  registered operand B, to the ALU busB input.
- dbgData  output  DATA_WIDTH  combinational contents of register dbgAddr.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low; one clock domain, clk.
  - reset_n=0 immediately clears every register, busA and busB to 0; dbgData then reads 0.
  - Reset asserted mid-write discards that write.
  - Reset release is sampled on the next rising edge.
- Register 0:
  - Hardwired to zero; writes to address 0 are ignored.
  - Reads of address 0 return 0, including through the bypass path.
- Write:
  - On the rising edge, if regWrite=1 and writeAddr!=0, regs[writeAddr] <= writeData.
  - Writes happen regardless of stall and flush.
- Read, with one-cycle latency, on each rising edge with reset_n=1:
  - flush=1: busA <= 0, busB <= 0.
  - Else stall=1: busA and busB hold.
  - Else busA <= value(rsAddr) and busB <= value(rtAddr).
- value(a):
  - 0 if a==0.
  - Else writeData if regWrite=1 and writeAddr==a (same-edge bypass, so writeback then decode needs no extra cycle).
  - Else regs[a].
- Both read ports may address the same register; both receive the identical value.
- Stall with a simultaneous write to the addressed register: busA/busB still hold the old value. The new value is visible on the first non-stalled edge.
- Flush and stall both high: flush wins.
- dbgData:
  - Purely combinational: regs[dbgAddr], 0 for address 0.
  - No bypass; it reflects the written value the cycle after the write edge.
- No other state. Implementation size is roughly 120–180 lines.

Test Plan:
- Reset: preload regs 1..31 with nonzero values, pulse reset_n low for 3 ns between edges -> busA=busB=0 immediately, with no clock edge needed. Then dbgAddr=5 -> dbgData=0.
- Write/read:
  - Write reg3=2 and reg4=4 on two edges.
  - Then rsAddr=3, rtAddr=4 -> after one edge busA=2, busB=4.
  - Cross-check with the ALU attached: opCode 0..9 each give the same results as driving busA=2, busB=4 directly.
- Bypass: same edge regWrite=1, writeAddr=7, writeData=0xDEADBEEF, rsAddr=7, rtAddr=7 -> busA=busB=0xDEADBEEF after that edge; dbgAddr=7 reads 0xDEADBEEF afterwards.
- Register 0: write writeAddr=0, writeData=0xFFFFFFFF with rsAddr=0 on the same edge -> busA=0; dbgAddr=0 -> dbgData=0.
- Stall/flush:
  - busA=2; stall=1 while writing reg3=9 -> busA stays 2.
  - Release stall -> busA=9.
  - flush=1 and stall=1 together -> busA=busB=0 on the next edge.
- Sweep: write reg i=i*3 for i=1..31, then read all pairs (i, 31-i) -> busA=3i and busB=3(31-i), except index 0, which reads 0.
